id_ex_hazard_ctrl: RTL and testbench

//  Sequencing controller for the ID/EX pipeline register and the stages upstream of it.
//  - Detects load-use hazards.
//  - Freezes the front end while a multi-cycle vector (48-bit) op occupies EX.
//  - Flushes wrong-path instructions after a taken branch.
//  - Drives PC, IF/ID and ID/EX enables, the ID/EX bubble and the IF/ID flush.
//  - Keeps a saturating stall-cycle counter for perf.

---
 rtl/id_ex_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX sequencing controller: load-use bubbles, vector-op freeze, branch flush,
// and a saturating count of cycles in which the PC was held.
module id_ex_hazard_ctrl #(
    parameter int VEC_LAT   = 4,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic [1:0]       ex_mem_to_reg,
    input  logic             ex_is_vec,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             vec_busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_VBUSY = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [2:0] VEC_RELOAD   = 3'(VEC_LAT - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC);
    localparam bit         VEC_MULTI    = (VEC_LAT > 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_next;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_branch;
    logic w_vec_start;
    logic w_load_use;

    assign w_branch    = ex_valid & branch_taken;
    assign w_vec_start = ex_valid & ex_is_vec & VEC_MULTI;
    assign w_load_use  = ex_valid & ex_reg_write & (ex_mem_to_reg == 2'b01) &
                         (ex_rd != 5'd0) & id_valid &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_branch) begin
                    w_state_next = S_FLUSH;
                    w_cnt_next   = FLUSH_RELOAD;
                end else if (w_vec_start) begin
                    w_state_next = S_VBUSY;
                    w_cnt_next   = VEC_RELOAD;
                end
            end
            S_VBUSY: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) w_state_next = S_RUN;
            end
            S_FLUSH: begin
                // A further taken branch restarts the flush window.
                if (w_branch) begin
                    w_cnt_next = FLUSH_RELOAD;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        vec_busy     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (w_branch) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_vec_start) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                        vec_busy = 1'b1;
                    end else if (w_load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                S_VBUSY: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    vec_busy = 1'b1;
                end
                S_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: a default instance plus a CNT_W=4 instance sharing
// the same stimulus, checked cycle by cycle against a queue of expected outputs.
module tb_id_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic [1:0] ex_mem_to_reg;
    logic       ex_is_vec;
    logic       branch_taken;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, vec_busy;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic        pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_bubble_s, vec_busy_s;
    logic [1:0]  state_s;
    logic [3:0]  stall_cycles_s;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl #(.VEC_LAT(4), .FLUSH_CYC(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_is_vec(ex_is_vec), .branch_taken(branch_taken), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_bubble(id_ex_bubble), .vec_busy(vec_busy), .state(state),
        .stall_cycles(stall_cycles)
    );

    id_ex_hazard_ctrl #(.VEC_LAT(4), .FLUSH_CYC(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_is_vec(ex_is_vec), .branch_taken(branch_taken), .pc_en(pc_en_s),
        .if_id_en(if_id_en_s), .if_id_flush(if_id_flush_s), .id_ex_en(id_ex_en_s),
        .id_ex_bubble(id_ex_bubble_s), .vec_busy(vec_busy_s), .state(state_s),
        .stall_cycles(stall_cycles_s)
    );

    // Packed view: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, vec_busy, state}
    wire [7:0] obs   = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, vec_busy, state};
    wire [7:0] obs_s = {pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_bubble_s,
                        vec_busy_s, state_s};

    localparam logic [7:0] E_DEF   = 8'b1101_0000;
    localparam logic [7:0] E_LU    = 8'b0001_1000;
    localparam logic [7:0] E_VSTRT = 8'b0000_0100;
    localparam logic [7:0] E_VBUSY = 8'b0000_0101;
    localparam logic [7:0] E_BR    = 8'b1111_1000;
    localparam logic [7:0] E_FLUSH = 8'b1111_1010;

    localparam int K_NOP = 0, K_ALU = 1, K_LOAD5 = 2, K_LOAD0 = 3, K_LOAD3 = 4,
                   K_LOAD5_NOUSE = 5, K_VEC = 6, K_BR = 7, K_BR_LOAD = 8;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp_v;
    logic [15:0] exp_stall   = '0;
    logic [3:0]  exp_stall_s = '0;

    // ID always holds an instruction reading x3 and x5; kind selects what sits in EX.
    task automatic apply_ex(input int kind);
        id_valid      = 1'b1;
        id_rs1        = 5'd3;
        id_rs2        = 5'd5;
        id_use_rs1    = 1'b1;
        id_use_rs2    = 1'b1;
        ex_valid      = 1'b0;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 2'b00;
        ex_is_vec     = 1'b0;
        branch_taken  = 1'b0;
        case (kind)
            K_ALU:         begin ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; end
            K_LOAD5:       begin ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_to_reg = 2'b01; end
            K_LOAD0:       begin ex_valid = 1'b1; ex_rd = 5'd0; ex_reg_write = 1'b1; ex_mem_to_reg = 2'b01; end
            K_LOAD3:       begin ex_valid = 1'b1; ex_rd = 5'd3; ex_reg_write = 1'b1; ex_mem_to_reg = 2'b01; end
            K_LOAD5_NOUSE: begin ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_to_reg = 2'b01; id_use_rs2 = 1'b0; end
            K_VEC:         begin ex_valid = 1'b1; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_is_vec = 1'b1; end
            K_BR:          begin ex_valid = 1'b1; branch_taken = 1'b1; end
            K_BR_LOAD:     begin ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_to_reg = 2'b01; branch_taken = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic note_stall(input logic [7:0] e);
        if (!e[7]) begin
            exp_stall = exp_stall + 16'd1;
            if (exp_stall_s != 4'hF) exp_stall_s = exp_stall_s + 4'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply_ex(K_BR_LOAD);
        #1;
        sb.push_back(E_DEF);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL reset_outputs got=%b expected=%b", obs, exp_v); fails++;
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles_s !== 4'd0) begin
            $display("FAIL reset_stall got=%0d/%0d expected=0/0", stall_cycles, stall_cycles_s); fails++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply_ex(K_NOP);
        rst = 1'b0;
        exp_stall = '0; exp_stall_s = '0;
    endtask

    task automatic test_load_use();
        int         kinds [8] = '{K_LOAD5, K_NOP, K_LOAD0, K_NOP, K_LOAD3, K_NOP, K_LOAD5_NOUSE, K_ALU};
        logic [7:0] exps  [8] = '{E_LU, E_DEF, E_DEF, E_DEF, E_LU, E_DEF, E_DEF, E_DEF};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply_ex(kinds[i]);
            sb.push_back(exps[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL load_use[%0d] got=%b expected=%b", i, obs, exp_v); fails++;
            end
            checks++;
            if (stall_cycles !== exp_stall) begin
                $display("FAIL load_use_stall[%0d] got=%0d expected=%0d", i, stall_cycles, exp_stall); fails++;
            end
            note_stall(exp_v);
        end
    endtask

    // Branch and load-use arriving while the vector op holds EX must be ignored.
    task automatic test_vector();
        int         kinds [6] = '{K_VEC, K_VEC, K_BR, K_LOAD5, K_NOP, K_NOP};
        logic [7:0] exps  [6] = '{E_VSTRT, E_VBUSY, E_VBUSY, E_VBUSY, E_DEF, E_DEF};
        logic [15:0] start_stall;
        start_stall = exp_stall;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply_ex(kinds[i]);
            sb.push_back(exps[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL vector[%0d] got=%b expected=%b", i, obs, exp_v); fails++;
            end
            note_stall(exp_v);
        end
        checks++;
        if (stall_cycles !== start_stall + 16'd4) begin
            $display("FAIL vector_stall_delta got=%0d expected=%0d", stall_cycles, start_stall + 16'd4); fails++;
        end
    endtask

    task automatic test_branch_load_use();
        int         kinds [3] = '{K_BR_LOAD, K_LOAD5, K_NOP};
        logic [7:0] exps  [3] = '{E_BR, E_FLUSH, E_DEF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply_ex(kinds[i]);
            sb.push_back(exps[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL branch_load_use[%0d] got=%b expected=%b", i, obs, exp_v); fails++;
            end
            checks++;
            if (stall_cycles !== exp_stall) begin
                $display("FAIL branch_stall[%0d] got=%0d expected=%0d", i, stall_cycles, exp_stall); fails++;
            end
            note_stall(exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int         kinds [4] = '{K_BR, K_BR, K_NOP, K_NOP};
        logic [7:0] exps  [4] = '{E_BR, E_FLUSH, E_FLUSH, E_DEF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply_ex(kinds[i]);
            sb.push_back(exps[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL back_to_back[%0d] got=%b expected=%b", i, obs, exp_v); fails++;
            end
            note_stall(exp_v);
        end
    endtask

    task automatic test_rst_mid_vbusy();
        int         kinds [3] = '{K_VEC, K_VEC, K_VEC};
        logic [7:0] exps  [3] = '{E_VSTRT, E_VBUSY, E_VBUSY};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply_ex(kinds[i]);
            sb.push_back(exps[i]);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL rst_mid_pre[%0d] got=%b expected=%b", i, obs, exp_v); fails++;
            end
            note_stall(exp_v);
        end
        // Third cycle is VBUSY with cnt=2; assert reset between clock edges.
        #2 rst = 1'b1;
        exp_stall = '0; exp_stall_s = '0;
        sb.push_back(E_DEF);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL rst_mid_outputs got=%b expected=%b", obs, exp_v); fails++;
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles_s !== 4'd0) begin
            $display("FAIL rst_mid_stall got=%0d/%0d expected=0/0", stall_cycles, stall_cycles_s); fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        apply_ex(K_NOP);
        sb.push_back(E_DEF);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            $display("FAIL rst_mid_release got=%b expected=%b", obs, exp_v); fails++;
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_stall = '0; exp_stall_s = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            apply_ex(K_VEC);
            sb.push_back((i % 4 == 0) ? E_VSTRT : E_VBUSY);
            #1;
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || obs_s !== exp_v) begin
                $display("FAIL saturation[%0d] got=%b/%b expected=%b", i, obs, obs_s, exp_v); fails++;
            end
            checks++;
            if (stall_cycles_s !== exp_stall_s) begin
                $display("FAIL saturation_cnt[%0d] got=%0d expected=%0d", i, stall_cycles_s, exp_stall_s); fails++;
            end
            note_stall(exp_v);
        end
        @(negedge clk);
        apply_ex(K_NOP);
        #1;
        checks++;
        if (stall_cycles_s !== 4'd15) begin
            $display("FAIL saturation_final got=%0d expected=15", stall_cycles_s); fails++;
        end
        checks++;
        if (stall_cycles !== 16'd80) begin
            $display("FAIL wide_counter_final got=%0d expected=80", stall_cycles); fails++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_vector();
        test_branch_load_use();
        test_back_to_back();
        test_rst_mid_vbusy();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
